store_data_aligner: RTL and testbench

STORE_DATA_ALIGNER -- requirements
Module: store_data_aligner

---
 rtl/store_data_aligner.sv | 186 ++++++++++++++++++
 tb/tb_store_data_aligner.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_data_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : store_data_aligner
//  Description : Turns a right-justified store request (SB/SH/SW) into one or
//                two word-aligned, byte-masked memory write beats. A store
//                that crosses a word boundary is split into two beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_data_aligner #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [2:0]            req_func,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  output logic                  err
);

  // Store funct3 encodings.
  localparam logic [2:0] C_FUNC_SB = 3'b000;
  localparam logic [2:0] C_FUNC_SH = 3'b001;
  localparam logic [2:0] C_FUNC_SW = 3'b010;

  // Byte distance between the two beats of a split store.
  localparam logic [ADDR_WIDTH-1:0] C_WORD_BYTES = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  state_e                    state_q, state_d;

  // Captured beat contents; beat1 address is derived from beat0 address.
  logic [ADDR_WIDTH-1:0]     b0_addr_q, b0_addr_d;
  logic [DATA_WIDTH-1:0]     b0_wdata_q, b0_wdata_d;
  logic [3:0]                b0_wmask_q, b0_wmask_d;
  logic [DATA_WIDTH-1:0]     b1_wdata_q, b1_wdata_d;
  logic [3:0]                b1_wmask_q, b1_wmask_d;
  logic                      split_q, split_d;
  logic                      err_q, err_d;

  // Request decode.
  logic                      accept;
  logic                      func_ok;
  logic [1:0]                offset;
  logic [3:0]                size_mask;
  logic [DATA_WIDTH-1:0]     sized_data;
  logic [7:0]                mask8;
  logic [2*DATA_WIDTH-1:0]   data64;

  // Beat presentation.
  logic [ADDR_WIDTH-1:0]     b1_addr;
  logic [DATA_WIDTH-1:0]     beat_wdata;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign offset    = req_addr[1:0];
  assign b1_addr   = b0_addr_q + C_WORD_BYTES;   // wraps naturally at the top
  assign err       = err_q;

  // Decode access size, zero the unused bytes and shift into lane position.
  always_comb begin
    size_mask  = 4'b0000;
    func_ok    = 1'b1;
    sized_data = '0;
    case (req_func)
      C_FUNC_SB: size_mask = 4'b0001;
      C_FUNC_SH: size_mask = 4'b0011;
      C_FUNC_SW: size_mask = 4'b1111;
      default: begin
        size_mask = 4'b0000;
        func_ok   = 1'b0;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      sized_data[8*i +: 8] = size_mask[i] ? req_data[8*i +: 8] : 8'h00;
    end
    mask8  = {4'b0000, size_mask} << offset;
    data64 = {{DATA_WIDTH{1'b0}}, sized_data} << {offset, 3'b000};
  end

  // Beat contents load only when a supported store is accepted.
  always_comb begin
    b0_addr_d  = b0_addr_q;
    b0_wdata_d = b0_wdata_q;
    b0_wmask_d = b0_wmask_q;
    b1_wdata_d = b1_wdata_q;
    b1_wmask_d = b1_wmask_q;
    split_d    = split_q;
    err_d      = accept && !func_ok;
    if (accept && func_ok) begin
      b0_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
      b0_wdata_d = data64[DATA_WIDTH-1:0];
      b0_wmask_d = mask8[3:0];
      b1_wdata_d = data64[2*DATA_WIDTH-1:DATA_WIDTH];
      b1_wmask_d = mask8[7:4];
      split_d    = |mask8[7:4];
    end
  end

  // Sequence IDLE -> BEAT0 [-> BEAT1] -> IDLE on memory handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && func_ok) state_d = BEAT0;
      end
      BEAT0: begin
        if (mem_ready) state_d = split_q ? BEAT1 : IDLE;
      end
      BEAT1: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured beat registers; reset abandons any in-flight store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      b0_addr_q  <= '0;
      b0_wdata_q <= '0;
      b0_wmask_q <= 4'b0000;
      b1_wdata_q <= '0;
      b1_wmask_q <= 4'b0000;
      split_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      b0_addr_q  <= b0_addr_d;
      b0_wdata_q <= b0_wdata_d;
      b0_wmask_q <= b0_wmask_d;
      b1_wdata_q <= b1_wdata_d;
      b1_wmask_q <= b1_wmask_d;
      split_q    <= split_d;
      err_q      <= err_d;
    end
  end

  // Present the current beat straight from registers; all-zero bus in IDLE.
  always_comb begin
    mem_valid  = 1'b0;
    mem_addr   = '0;
    beat_wdata = '0;
    mem_wmask  = 4'b0000;
    case (state_q)
      BEAT0: begin
        mem_valid  = 1'b1;
        mem_addr   = b0_addr_q;
        beat_wdata = b0_wdata_q;
        mem_wmask  = b0_wmask_q;
      end
      BEAT1: begin
        mem_valid  = 1'b1;
        mem_addr   = b1_addr;
        beat_wdata = b1_wdata_q;
        mem_wmask  = b1_wmask_q;
      end
      default: begin
        mem_valid = 1'b0;
      end
    endcase
  end

  // Guarantee disabled byte lanes never carry data onto the bus.
  always_comb begin
    mem_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      mem_wdata[8*i +: 8] = mem_wmask[i] ? beat_wdata[8*i +: 8] : 8'h00;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_data_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_data_aligner
//  Description : Self-checking bench for store_data_aligner: directed cases,
//                error and reset scenarios, and randomized stores compared
//                against a byte-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_data_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic [2:0]  req_func = 3'b000;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        err;

  int tests = 0;
  int fails = 0;

  // Beats observed by the collector.
  logic [31:0] obs_addr [4];
  logic [31:0] obs_data [4];
  logic [3:0]  obs_mask [4];
  int          obs_n, obs_unstable, obs_cycles;
  bit          obs_timeout;

  // Reference model results.
  logic [31:0] exp_addr [2];
  logic [31:0] exp_data [2];
  logic [3:0]  exp_mask [2];
  int          exp_n;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    int          stall;
    int          n;
    int          cyc;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  m0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  m1;
  } dcase_t;

  store_data_aligner #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_func  (req_func),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
    $fatal(1, "watchdog expired");
  end

  // Byte-by-byte model: each store byte k lands at address a+k, in the word
  // that contains it, at lane (a+k)%4. Bytes beyond the first word form beat1.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int          nbytes;
    int          w;
    int          lane;
    logic [31:0] base;
    logic [31:0] ba;
    nbytes = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : (f == 3'd2) ? 4 : 0;
    base = a & 32'hFFFF_FFFC;
    exp_addr[0] = base;
    exp_addr[1] = base + 32'd4;
    exp_data[0] = 32'h0; exp_data[1] = 32'h0;
    exp_mask[0] = 4'h0; exp_mask[1] = 4'h0;
    exp_n = (nbytes == 0) ? 0 : 1;
    for (int k = 0; k < nbytes; k++) begin
      ba   = a + 32'(k);
      w    = ((ba & 32'hFFFF_FFFC) == base) ? 0 : 1;
      lane = int'(ba[1:0]);
      exp_data[w][8*lane +: 8] = d[8*k +: 8];
      exp_mask[w][lane] = 1'b1;
      if (w == 1) exp_n = 2;
    end
  endtask

  // Present one request; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 50) begin
      tests++; fails++;
      $display("FAIL issue_wait: req_ready=%0b after %0d cycles, required=1", req_ready, w);
    end
    req_valid = 1'b1; req_addr = a; req_data = d; req_func = f;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom; req_data = $urandom; req_func = 3'($urandom);
  endtask

  // Record beats until the bus returns idle. mode 0: stall the first stall_n
  // cycles then ready; mode 1: random mem_ready.
  task automatic collect(input int mode, input int stall_n);
    logic [31:0] pa, pd;
    logic [3:0]  pm;
    bit          held, done;
    int          stalls;
    obs_n = 0; obs_unstable = 0; obs_timeout = 1'b1; obs_cycles = -1;
    held = 1'b0; done = 1'b0; stalls = 0;
    pa = 32'h0; pd = 32'h0; pm = 4'h0;
    for (int c = 0; c < 64; c++) begin
      if (!done) begin
        if (!mem_valid) begin
          done = 1'b1; obs_timeout = 1'b0; obs_cycles = c;
          mem_ready = 1'b0;
        end else begin
          if (held && (mem_addr !== pa || mem_wdata !== pd || mem_wmask !== pm))
            obs_unstable++;
          if (mode == 0) begin
            mem_ready = (stalls < stall_n) ? 1'b0 : 1'b1;
            if (!mem_ready) stalls++;
          end else begin
            mem_ready = 1'($urandom_range(0, 1));
          end
          pa = mem_addr; pd = mem_wdata; pm = mem_wmask;
          if (mem_ready) begin
            if (obs_n < 4) begin
              obs_addr[obs_n] = mem_addr;
              obs_data[obs_n] = mem_wdata;
              obs_mask[obs_n] = mem_wmask;
            end
            obs_n++;
            held = 1'b0;
          end else begin
            held = 1'b1;
          end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({mem_valid, err, mem_addr, mem_wdata, mem_wmask} !== 70'h0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0b err=%0b addr=%h data=%h mask=%h required all 0",
               mem_valid, err, mem_addr, mem_wdata, mem_wmask);
    end
    #3 rst_n = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: req_ready=%0b required=1", req_ready);
    end
  endtask

  task automatic test_directed();
    dcase_t tbl [6];
    tbl[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 3'd2, 0, 1, 1,
               32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'h0, 4'h0};
    tbl[1] = '{32'h0000_0203, 32'h1234_56AB, 3'd0, 0, 1, 1,
               32'h0000_0200, 32'hAB00_0000, 4'h8, 32'h0, 32'h0, 4'h0};
    tbl[2] = '{32'h0000_0102, 32'h1122_3344, 3'd2, 0, 2, 2,
               32'h0000_0100, 32'h3344_0000, 4'hC, 32'h0000_0104, 32'h0000_1122, 4'h3};
    tbl[3] = '{32'h0000_00FF, 32'h0000_BEEF, 3'd1, 3, 2, 5,
               32'h0000_00FC, 32'hEF00_0000, 4'h8, 32'h0000_0100, 32'h0000_00BE, 4'h1};
    tbl[4] = '{32'hFFFF_FFFE, 32'hA1B2_C3D4, 3'd2, 0, 2, 2,
               32'hFFFF_FFFC, 32'hC3D4_0000, 4'hC, 32'h0000_0000, 32'h0000_A1B2, 4'h3};
    tbl[5] = '{32'h0000_0101, 32'hFFFF_5678, 3'd1, 1, 1, 2,
               32'h0000_0100, 32'h0056_7800, 4'h6, 32'h0, 32'h0, 4'h0};
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].a, tbl[i].d, tbl[i].f);
      collect(0, tbl[i].stall);
      tests++;
      if (obs_timeout || obs_n != tbl[i].n || obs_cycles != tbl[i].cyc) begin
        fails++;
        $display("FAIL dir%0d_count: beats=%0d cycles=%0d timeout=%0b required beats=%0d cycles=%0d",
                 i, obs_n, obs_cycles, obs_timeout, tbl[i].n, tbl[i].cyc);
      end
      tests++;
      if (obs_unstable != 0) begin
        fails++;
        $display("FAIL dir%0d_stable: changes while stalled=%0d required=0", i, obs_unstable);
      end
      tests++;
      if (obs_n < 1 || obs_addr[0] !== tbl[i].a0 || obs_data[0] !== tbl[i].d0
          || obs_mask[0] !== tbl[i].m0) begin
        fails++;
        $display("FAIL dir%0d_beat0: addr=%h data=%h mask=%h required addr=%h data=%h mask=%h",
                 i, obs_addr[0], obs_data[0], obs_mask[0], tbl[i].a0, tbl[i].d0, tbl[i].m0);
      end
      if (tbl[i].n == 2) begin
        tests++;
        if (obs_n < 2 || obs_addr[1] !== tbl[i].a1 || obs_data[1] !== tbl[i].d1
            || obs_mask[1] !== tbl[i].m1) begin
          fails++;
          $display("FAIL dir%0d_beat1: addr=%h data=%h mask=%h required addr=%h data=%h mask=%h",
                   i, obs_addr[1], obs_data[1], obs_mask[1], tbl[i].a1, tbl[i].d1, tbl[i].m1);
        end
      end
      tests++;
      if (req_ready !== 1'b1 || {mem_addr, mem_wdata, mem_wmask} !== 68'h0) begin
        fails++;
        $display("FAIL dir%0d_idle: ready=%0b addr=%h data=%h mask=%h required ready=1 bus 0",
                 i, req_ready, mem_addr, mem_wdata, mem_wmask);
      end
    end
  endtask

  task automatic test_error();
    int vcount;
    mem_ready = 1'b1;
    issue(32'h0000_0040, 32'hCAFE_F00D, 3'b011);
    tests++;
    if (err !== 1'b1 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL err_pulse: err=%0b valid=%0b ready=%0b required err=1 valid=0 ready=1",
               err, mem_valid, req_ready);
    end
    vcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (mem_valid || err) vcount++;
    end
    tests++;
    if (vcount != 0) begin
      fails++;
      $display("FAIL err_after: cycles with err/valid=%0d required=0", vcount);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int vcount;
    issue(32'h0000_0102, 32'h5566_7788, 3'd2);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    tests++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_0104) begin
      fails++;
      $display("FAIL rstmid_inbeat1: valid=%0b addr=%h required valid=1 addr=00000104",
               mem_valid, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (mem_valid !== 1'b0 || {mem_addr, mem_wdata, mem_wmask} !== 68'h0 || err !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async: valid=%0b addr=%h data=%h mask=%h err=%0b required all 0",
               mem_valid, mem_addr, mem_wdata, mem_wmask, err);
    end
    mem_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_release: ready=%0b valid=%0b required ready=1 valid=0",
               req_ready, mem_valid);
    end
    vcount = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (mem_valid) vcount++;
    end
    tests++;
    if (vcount != 0) begin
      fails++;
      $display("FAIL rstmid_nobeat: valid cycles=%0d required=0", vcount);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [2:0]  f;
    int          bad;
    for (int it = 0; it < 300; it++) begin
      a = $urandom;
      if (it % 5 == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      d = $urandom;
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      model(a, d, f);
      mem_ready = 1'($urandom_range(0, 1));
      issue(a, d, f);
      if (exp_n == 0) begin
        tests++;
        if (err !== 1'b1 || mem_valid !== 1'b0) begin
          fails++;
          $display("FAIL rnd%0d_err: err=%0b valid=%0b required err=1 valid=0 func=%0d",
                   it, err, mem_valid, f);
        end
        @(posedge clk); #1;
        tests++;
        if (err !== 1'b0 || mem_valid !== 1'b0) begin
          fails++;
          $display("FAIL rnd%0d_errlen: err=%0b valid=%0b required err=0 valid=0",
                   it, err, mem_valid);
        end
      end else begin
        tests++;
        if (err !== 1'b0 || mem_valid !== 1'b1) begin
          fails++;
          $display("FAIL rnd%0d_start: err=%0b valid=%0b required err=0 valid=1", it, err, mem_valid);
        end
        collect(1, 0);
        tests++;
        if (obs_timeout || obs_n != exp_n || obs_unstable != 0) begin
          fails++;
          $display("FAIL rnd%0d_beats: beats=%0d unstable=%0d timeout=%0b required beats=%0d unstable=0",
                   it, obs_n, obs_unstable, obs_timeout, exp_n);
        end
        bad = 0;
        for (int b = 0; b < exp_n && b < obs_n; b++) begin
          if (obs_addr[b] !== exp_addr[b] || obs_data[b] !== exp_data[b]
              || obs_mask[b] !== exp_mask[b]) begin
            bad++;
            $display("FAIL rnd%0d_beat%0d: addr=%h data=%h mask=%h required addr=%h data=%h mask=%h",
                     it, b, obs_addr[b], obs_data[b], obs_mask[b],
                     exp_addr[b], exp_data[b], exp_mask[b]);
          end
        end
        tests++;
        if (bad != 0) fails++;
      end
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_error();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
